// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM slot-serialised link (receive and transmit sides).
package tdm_pkg;

   // Number of lanes carried per frame and the width of the slot index.
   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;

   // First and last slot of a frame.
   localparam logic [SLOT_W-1:0] SLOT_FIRST = 2'd0;
   localparam logic [SLOT_W-1:0] SLOT_LAST  = 2'd3;

   // Framing state: searching for a sync marker, or aligned to frames.
   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

   // Low bit of lane k inside a packed frame word.
   function automatic int lane_lsb(input int lane, input int data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/tdm_demux1x4_if.sv
// Serial-beat input side and parallel-frame output side of the 1:4 TDM demux.
interface tdm_demux1x4_if #(
   parameter int DATA_W = 1
);
   import tdm_pkg::*;

   logic                       in_valid;
   logic [DATA_W-1:0]          in_data;
   logic                       in_sync;
   logic [NUM_CH*DATA_W-1:0]   out_ch;
   logic                       out_valid;
   logic [SLOT_W-1:0]          slot;
   logic                       locked;
   logic                       sync_err;

   // Link side: drives beats, observes the rebuilt frame.
   modport master (
      output in_valid,
      output in_data,
      output in_sync,
      input  out_ch,
      input  out_valid,
      input  slot,
      input  locked,
      input  sync_err
   );

   // Demux side: consumes beats, produces the frame word and status.
   modport slave (
      input  in_valid,
      input  in_data,
      input  in_sync,
      output out_ch,
      output out_valid,
      output slot,
      output locked,
      output sync_err
   );

endinterface

// File: rtl/tdm_demux1x4.sv
// Time-division 1:4 demultiplexer: rebuilds a 4-lane word from a sync-framed
// serial beat stream and pulses out_valid once per completed frame.
module tdm_demux1x4
   import tdm_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic           clk,
   input  logic           reset,
   tdm_demux1x4_if.slave  bus
);

   tdm_state_e                 state_r;
   logic [SLOT_W-1:0]          slot_r;
   logic [DATA_W-1:0]          stage_r [NUM_CH-1];
   logic [NUM_CH*DATA_W-1:0]   out_ch_r;
   logic                       out_valid_r;
   logic                       sync_err_r;

   // Framing state machine, lane staging and registered frame outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= HUNT;
         slot_r      <= SLOT_FIRST;
         stage_r[0]  <= '0;
         stage_r[1]  <= '0;
         stage_r[2]  <= '0;
         out_ch_r    <= '0;
         out_valid_r <= 1'b0;
         sync_err_r  <= 1'b0;
      end else begin
         // Pulses default low; only an accepted beat can raise them.
         out_valid_r <= 1'b0;
         sync_err_r  <= 1'b0;
         if (bus.in_valid) begin
            case (state_r)
               HUNT: begin
                  // Non-sync beats are dropped silently while hunting.
                  if (bus.in_sync) begin
                     stage_r[0] <= bus.in_data;
                     slot_r     <= 2'd1;
                     state_r    <= LOCKED;
                  end else begin
                     slot_r     <= SLOT_FIRST;
                  end
               end
               LOCKED: begin
                  if (bus.in_sync) begin
                     // A sync anywhere but slot 0 abandons the partial frame;
                     // the beat still starts a fresh frame.
                     if (slot_r != SLOT_FIRST) begin
                        sync_err_r <= 1'b1;
                     end else begin
                        sync_err_r <= 1'b0;
                     end
                     stage_r[0] <= bus.in_data;
                     slot_r     <= 2'd1;
                  end else if (slot_r == SLOT_FIRST) begin
                     // Missing sync marker: alignment lost.
                     sync_err_r <= 1'b1;
                     slot_r     <= SLOT_FIRST;
                     state_r    <= HUNT;
                  end else if (slot_r == SLOT_LAST) begin
                     out_ch_r    <= {bus.in_data, stage_r[2], stage_r[1], stage_r[0]};
                     out_valid_r <= 1'b1;
                     slot_r      <= SLOT_FIRST;
                  end else begin
                     case (slot_r)
                        2'd1:    stage_r[1] <= bus.in_data;
                        2'd2:    stage_r[2] <= bus.in_data;
                        default: stage_r[0] <= stage_r[0];
                     endcase
                     slot_r <= slot_r + 2'd1;
                  end
               end
               default: begin
                  state_r <= HUNT;
                  slot_r  <= SLOT_FIRST;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign bus.out_ch    = out_ch_r;
   assign bus.out_valid = out_valid_r;
   assign bus.slot      = slot_r;
   assign bus.locked    = (state_r == LOCKED);
   assign bus.sync_err  = sync_err_r;

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Self-checking bench for tdm_demux1x4: directed framing scenarios plus a
// randomized beat stream, all checked every cycle against a frame-level model.
module tb_tdm_demux1x4;

   localparam int DW = 4;

   logic clk;
   logic reset;

   tdm_demux1x4_if #(.DATA_W(DW)) bus ();

   tdm_demux1x4 #(.DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // hunting : no frame alignment known
   // filled  : how many lanes of the current frame have been collected
   bit            model_live = 1'b0;
   bit            hunting    = 1'b1;
   int            filled     = 0;
   logic [DW-1:0] lanes [4];
   logic [4*DW-1:0] m_ch    = '0;
   logic            m_valid = 1'b0;
   logic            m_err   = 1'b0;

   task automatic model_step();
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (reset) begin
         model_live = 1'b1;
         hunting    = 1'b1;
         filled     = 0;
         m_ch       = '0;
      end else if (bus.in_valid) begin
         if (bus.in_sync) begin
            if (!hunting && filled != 0) m_err = 1'b1;
            hunting  = 1'b0;
            lanes[0] = bus.in_data;
            filled   = 1;
         end else if (hunting) begin
            filled = 0;
         end else if (filled == 0) begin
            m_err   = 1'b1;
            hunting = 1'b1;
         end else begin
            lanes[filled] = bus.in_data;
            filled++;
            if (filled == 4) begin
               m_ch    = {lanes[3], lanes[2], lanes[1], lanes[0]};
               m_valid = 1'b1;
               filled  = 0;
            end
         end
      end
   endtask

   // Advance the model on each edge and compare all outputs just after it.
   always @(posedge clk) begin
      model_step();
      #1;
      if (model_live) begin
         chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
         chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
         chk("sync_err",  32'(bus.sync_err),  32'(m_err));
         chk("slot",      32'(bus.slot),      32'(filled));
         chk("locked",    32'(bus.locked),    32'(!hunting));
      end
   end

   // ---------------- stimulus ----------------
   task automatic beat(input logic s, input logic [DW-1:0] d, input int gap);
      bus.in_valid = 1'b1;
      bus.in_sync  = s;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      int tx_pos;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Some traffic, then reset mid-frame for 3 cycles.
      beat(1'b1, 4'h3, 0);
      beat(1'b0, 4'h5, 0);
      beat(1'b0, 4'h7, 0);
      beat(1'b0, 4'h9, 0);
      beat(1'b1, 4'hA, 0);
      beat(1'b0, 4'hB, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_out_ch",  32'(bus.out_ch),    32'h0);
      chk("rst_valid",   32'(bus.out_valid), 32'h0);
      chk("rst_locked",  32'(bus.locked),    32'h0);
      chk("rst_slot",    32'(bus.slot),      32'h0);
      chk("rst_err",     32'(bus.sync_err),  32'h0);

      // Basic frame, consecutive beats: lanes 0,1,0,1.
      beat(1'b1, 4'h0, 0);
      beat(1'b0, 4'h1, 0);
      beat(1'b0, 4'h0, 0);
      beat(1'b0, 4'h1, 0);
      chk("s2_out_ch",  32'(bus.out_ch),    32'h1010);
      chk("s2_valid",   32'(bus.out_valid), 32'h1);
      chk("s2_slot",    32'(bus.slot),      32'h0);
      chk("s2_locked",  32'(bus.locked),    32'h1);
      @(negedge clk);
      chk("s2_pulse1",  32'(bus.out_valid), 32'h0);

      // Same frame with 2-cycle idle gaps between beats.
      beat(1'b1, 4'h0, 2);
      beat(1'b0, 4'h1, 2);
      beat(1'b0, 4'h0, 2);
      beat(1'b0, 4'h1, 0);
      chk("s3_out_ch",  32'(bus.out_ch),    32'h1010);
      chk("s3_valid",   32'(bus.out_valid), 32'h1);

      // Early sync on slot 2 discards the partial frame.
      beat(1'b1, 4'h1, 0);
      beat(1'b0, 4'h1, 0);
      beat(1'b1, 4'h0, 0);
      chk("s4_err",     32'(bus.sync_err),  32'h1);
      chk("s4_novalid", 32'(bus.out_valid), 32'h0);
      chk("s4_hold",    32'(bus.out_ch),    32'h1010);
      beat(1'b0, 4'h0, 0);
      beat(1'b0, 4'h1, 0);
      beat(1'b0, 4'h1, 0);
      chk("s4_out_ch",  32'(bus.out_ch),    32'h1100);
      chk("s4_valid",   32'(bus.out_valid), 32'h1);

      // Missing sync at slot 0 drops lock; a sync beat relocks.
      beat(1'b0, 4'h1, 0);
      chk("s5_err",     32'(bus.sync_err),  32'h1);
      chk("s5_locked",  32'(bus.locked),    32'h0);
      beat(1'b1, 4'h1, 0);
      chk("s5_relock",  32'(bus.locked),    32'h1);
      chk("s5_slot",    32'(bus.slot),      32'h1);
      beat(1'b0, 4'h2, 0);
      beat(1'b0, 4'h3, 0);
      beat(1'b0, 4'h4, 0);

      // 8 back-to-back frames, every lane carrying the frame index.
      for (int f = 0; f < 8; f++) begin
         logic [DW-1:0] idx;
         idx = DW'(f);
         bus.in_valid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            bus.in_sync = (k == 0);
            bus.in_data = idx;
            @(negedge clk);
         end
         chk("s6_out_ch", 32'(bus.out_ch),    32'({4{idx}}));
         chk("s6_valid",  32'(bus.out_valid), 32'h1);
      end
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      @(negedge clk);

      // Randomized stream: mostly well-framed, with occasional stray syncs,
      // missing syncs, idle cycles and resets.
      tx_pos = 0;
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 299) == 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_sync  = (tx_pos == 0) ^ ($urandom_range(0, 15) == 0);
         bus.in_data  = DW'($urandom);
         if (bus.in_valid) tx_pos = (tx_pos + 1) % 4;
         @(negedge clk);
      end
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tdm_demux1x4.md
Name: tdm_demux1x4

Overview:
Time-division 1-to-4 demultiplexer. It is the receive-side counterpart of the 4:1 mux path.
- Accepts a serial stream of lane samples, one slot per accepted beat, framed by a sync marker on slot 0.
- Rebuilds the 4-lane parallel word and presents it with a one-cycle valid pulse once per complete frame.
- Sits between a slot-serialised link and parallel consumers.

Parameters:
DATA_W, 1, width in bits of each lane sample (one slot's payload).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  beat qualifier; in_data/in_sync sampled only when high
in_data  input  DATA_W  sample for the current slot
in_sync  input  1  marks the beat as slot 0 of a frame
out_ch  output  4*DATA_W  frame word; lane k at bits [k*DATA_W +: DATA_W]
out_valid  output  1  one-cycle pulse; out_ch updated this cycle
slot  output  2  slot index the next accepted beat will occupy
locked  output  1  high in LOCKED state
sync_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset is synchronous and active-high on clk; no asynchronous reset anywhere.
- Reset values (next edge with reset high): state=HUNT, slot=0, staging lanes 0..2=0, out_ch=0, out_valid=0, sync_err=0, locked=0. Reset mid-frame discards the partial frame; out_ch clears to 0.
- Beats with in_valid=0 are ignored: no state, slot, or staging change. out_valid and sync_err are 0 on those cycles.
- HUNT state:
  - beat with in_sync=1: store in_data as lane 0, slot->1, go LOCKED.
  - beat with in_sync=0: dropped, stay HUNT, no error.
- LOCKED state, slot 1..2:
  - beat with in_sync=0: store to staging[slot], slot++.
- LOCKED state, slot=3, beat with in_sync=0:
  - out_ch <= {in_data, staging[2], staging[1], staging[0]}.
  - out_valid=1 on the following cycle (registered, latency 1 from the slot-3 beat).
  - slot->0.
- LOCKED state, slot=0:
  - beat with in_sync=1: store lane 0, slot->1.
  - beat with in_sync=0: sync_err pulse, beat dropped, go HUNT, slot=0.
- LOCKED state, slot 1..3, beat with in_sync=1 (early sync):
  - sync_err pulse.
  - Partial frame discarded; out_ch unchanged, no out_valid.
  - Beat is taken as the new slot 0: lane 0 stored, slot->1, stay LOCKED.
- out_ch holds its value between frames. Only a completed frame or reset changes it.
- Back-to-back frames at full rate (in_valid held high) produce out_valid every 4th cycle, with no bubble.
- sync_err and out_valid are never high in the same cycle: a frame completes only on a slot-3 beat without sync.
- Widths: slot is 2-bit and wraps 3->0 naturally. No arithmetic on data; the datapath is pure steering and registering.

Decomposition:
- Shared package tdm_pkg:
  - NUM_CH=4, SLOT_W=2.
  - State enum {HUNT, LOCKED}.
  - Lane-slice helper constants.
- Reuse the package for any future tdm_mux4x1 transmitter.
- No sub-module required. Optional: tdm_lane_bank (staging registers with write-enable per slot). Otherwise keep a single module.

Test Plan:
1. Reset asserted 3 cycles mid-stream, then released -> out_ch=0, out_valid=0, locked=0, slot=0, sync_err=0.
2. DATA_W=1; beats (sync,data) = (1,0),(0,1),(0,0),(0,1) on consecutive cycles -> one cycle after the 4th beat: out_ch=4'b1010, out_valid=1 for exactly 1 cycle, slot=0, locked=1.
3. Same frame as scenario 2 with in_valid=0 gaps of 2 cycles between beats -> identical out_ch=4'b1010, single out_valid pulse one cycle after the last beat.
4. Locked; beats (1,1),(0,1),(1,0),(0,0),(0,1),(0,1) -> sync_err pulse on the 3rd beat, no out_valid for the partial frame, then out_ch=4'b1100 with out_valid.
5. Locked; frame ends, next beat (0,1) at slot 0 -> sync_err pulse, locked=0. A following (1,1) relocks with slot=1.
6. 8 back-to-back frames with in_valid held high, lanes = frame index (DATA_W=4) -> out_valid every 4th cycle, out_ch lanes all equal that frame's index, no sync_err.
